// File: rtl/stable_window_monitor.sv
// Stability monitor for a sampled bus: registers sample-to-sample equality, hold length and early-change glitches.
// Optional embedded assertions are compiled when STABLE_WINDOW_MONITOR_SVA_EN is defined.
module stable_window_monitor #(
  parameter int WIDTH      = 8,
  parameter int MIN_STABLE = 3,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sig,
  output logic             stable,
  output logic             change,
  output logic             settled,
  output logic             glitch,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_SETTLING = 2'd1;
  localparam logic [1:0] S_SETTLED  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_Q   = CNT_W'(MIN_STABLE);
  // A freshly seen value is already settled when one sample suffices.
  localparam logic [1:0] S_FRESH = (MIN_STABLE == 1) ? S_SETTLED : S_SETTLING;

  logic [1:0]       state;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] hold_inc;

  assign hold_inc = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + 1'b1;
  assign settled  = (state == S_SETTLED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_EMPTY;
      prev       <= '0;
      stable     <= 1'b0;
      change     <= 1'b0;
      glitch     <= 1'b0;
      hold_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      change <= 1'b0;
      glitch <= 1'b0;
      if (en) begin
        prev <= sig;
        if (state == S_EMPTY) begin
          stable   <= 1'b0;
          hold_cnt <= CNT_W'(1);
          state    <= S_FRESH;
        end else if (sig == prev) begin
          stable   <= 1'b1;
          hold_cnt <= hold_inc;
          if (hold_inc >= MIN_Q) state <= S_SETTLED;
        end else begin
          stable   <= 1'b0;
          change   <= 1'b1;
          hold_cnt <= CNT_W'(1);
          state    <= S_FRESH;
          // Leaving SETTLED is legal; only an unsettled value changing is a glitch.
          if (state == S_SETTLING) begin
            glitch <= 1'b1;
            if (glitch_cnt != CNT_MAX) glitch_cnt <= glitch_cnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef STABLE_WINDOW_MONITOR_SVA_EN
  // sampled_q: the preceding edge took a sample; first_q: that sample came out of EMPTY.
  logic             sampled_q;
  logic             first_q;
  logic [WIDTH-1:0] prev_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sampled_q <= 1'b0;
      first_q   <= 1'b0;
      prev_d    <= '0;
    end else begin
      sampled_q <= en;
      if (en) begin
        prev_d  <= prev;
        first_q <= (state == S_EMPTY);
      end
    end
  end

  a_stable: assert property (@(posedge clk) disable iff (rst)
    (sampled_q && !first_q) |-> (stable == (prev == prev_d)))
    else $error("stable_window_monitor: stable mismatch at %0t", $time);

  a_glitch_change: assert property (@(posedge clk) disable iff (rst)
    sampled_q |-> (!glitch || change))
    else $error("stable_window_monitor: glitch without change at %0t", $time);

  a_no_glitch_min1: assert property (@(posedge clk) disable iff (rst)
    sampled_q |-> ((MIN_STABLE != 1) || !glitch))
    else $error("stable_window_monitor: glitch with MIN_STABLE=1 at %0t", $time);

  a_hold_mono: assert property (@(posedge clk) disable iff (rst)
    (sampled_q && !first_q) |-> ((hold_cnt >= $past(hold_cnt)) || (change && hold_cnt == CNT_W'(1))))
    else $error("stable_window_monitor: hold_cnt decreased at %0t", $time);
`endif

endmodule

// File: tb/tb_stable_window_monitor.sv
// Directed bench for stable_window_monitor: driver queues hand-computed expectations, monitor pops and compares each cycle.
module tb_stable_window_monitor;

  typedef struct packed {
    logic       stable;
    logic       change;
    logic       settled;
    logic       glitch;
    logic [3:0] hold;
    logic [3:0] gcnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] sig = 8'h00;
  logic       stable, change, settled, glitch;
  logic [3:0] hold_cnt, glitch_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  stable_window_monitor #(.WIDTH(8), .MIN_STABLE(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sig(sig),
    .stable(stable), .change(change), .settled(settled), .glitch(glitch),
    .hold_cnt(hold_cnt), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every edge that the driver annotated produces one registered result.
  always @(posedge clk) begin
    exp_t  e, a;
    string n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{stable, change, settled, glitch, hold_cnt, glitch_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%b ch=%b set=%b gl=%b hold=%0d gcnt=%0d, want st=%b ch=%b set=%b gl=%b hold=%0d gcnt=%0d",
                 n, a.stable, a.change, a.settled, a.glitch, a.hold, a.gcnt,
                 e.stable, e.change, e.settled, e.glitch, e.hold, e.gcnt);
      end
    end
  end

  task automatic step(input string n, input logic r, input logic e_in, input logic [7:0] s,
                      input logic st, input logic ch, input logic se, input logic gl,
                      input int h, input int g);
    @(negedge clk);
    rst = r; en = e_in; sig = s;
    exp_q.push_back('{st, ch, se, gl, 4'(h), 4'(g)});
    name_q.push_back(n);
  endtask

  task automatic do_reset(input string n);
    step(n, 1'b1, 1'b1, 8'hFF, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset: two cycles with sig=FF, en=1; plus reset winning over en=0.
    do_reset("reset0");
    do_reset("reset1");
    step("reset_en0", 1'b1, 1'b0, 8'hFF, 0, 0, 0, 0, 0, 0);

    // Settling on 0x5A.
    step("settle1", 0, 1, 8'h5A, 0, 0, 0, 0, 1, 0);
    step("settle2", 0, 1, 8'h5A, 1, 0, 0, 0, 2, 0);
    step("settle3", 0, 1, 8'h5A, 1, 0, 1, 0, 3, 0);
    step("settle4", 0, 1, 8'h5A, 1, 0, 1, 0, 4, 0);
    step("settle5", 0, 1, 8'h5A, 1, 0, 1, 0, 5, 0);

    // Legal change out of SETTLED, then a glitch, then a legal change again.
    step("chg_11a", 0, 1, 8'h11, 0, 1, 0, 0, 1, 0);
    step("chg_11b", 0, 1, 8'h11, 1, 0, 0, 0, 2, 0);
    step("glitch22", 0, 1, 8'h22, 0, 1, 0, 1, 1, 1);
    step("hold22b", 0, 1, 8'h22, 1, 0, 0, 0, 2, 1);
    step("hold22c", 0, 1, 8'h22, 1, 0, 1, 0, 3, 1);
    step("chg33", 0, 1, 8'h33, 0, 1, 0, 0, 1, 1);

    // Enable gating hides bus activity while disabled.
    do_reset("reset_gate");
    step("gate_a0a", 0, 1, 8'hA0, 0, 0, 0, 0, 1, 0);
    step("gate_a0b", 0, 1, 8'hA0, 1, 0, 0, 0, 2, 0);
    step("gate_off0b", 0, 0, 8'h0B, 1, 0, 0, 0, 2, 0);
    step("gate_offa0", 0, 0, 8'hA0, 1, 0, 0, 0, 2, 0);
    step("gate_on", 0, 1, 8'hA0, 1, 0, 1, 0, 3, 0);

    // Reset while SETTLING with hold_cnt=2 and sig changing.
    do_reset("reset_mid0");
    step("mid_44a", 0, 1, 8'h44, 0, 0, 0, 0, 1, 0);
    step("mid_44b", 0, 1, 8'h44, 1, 0, 0, 0, 2, 0);
    step("mid_rst", 1, 1, 8'h55, 0, 0, 0, 0, 0, 0);
    step("mid_first", 0, 1, 8'h55, 0, 0, 0, 0, 1, 0);

    // Saturation of hold_cnt, then of glitch_cnt.
    do_reset("reset_sat");
    for (int i = 1; i <= 20; i++)
      step($sformatf("hold_sat%0d", i), 0, 1, 8'h77, i > 1, 0, i >= 3, 0, (i > 15) ? 15 : i, 0);
    // First flip leaves SETTLED (no glitch); the next 17 flips are glitches.
    for (int k = 0; k <= 17; k++)
      step($sformatf("gl_sat%0d", k), 0, 1, (k % 2 == 0) ? 8'h00 : 8'h01,
           0, 1, 0, k > 0, 1, (k > 15) ? 15 : k);
    step("sat_idle", 0, 0, 8'h55, 0, 0, 0, 0, 1, 15);

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by %0t, want finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stable_window_monitor.md
# stable_window_monitor

Synthesizable, parametrised stability monitor for an N-bit bus. It is the hardware counterpart of the `$stable` check:
- Registers `stable`, the sample-to-sample equality result.
- Tracks how many consecutive samples the bus has held its value.
- Flags and counts every change that arrives before the bus has been stable for `MIN_STABLE` samples.

It sits beside any sampled control/data bus in the design and feeds status registers or a debug capture unit.

## Interface
- `WIDTH`, 8: width of monitored bus `sig` (≥1).
- `MIN_STABLE`, 3: samples a value must be held to count as settled (1 ≤ `MIN_STABLE` ≤ 2^`CNT_W`−1).
- `CNT_W`, 4: width of `hold_cnt` and `glitch_cnt`.

Ports:
- `clk` in 1: sampling clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample enable; an edge with `en`=0 is not a sample.
- `sig` in `WIDTH`: monitored bus.
- `stable` out 1: last sample equals the one before it.
- `change` out 1: one-cycle pulse; last sample differs from the one before it.
- `settled` out 1: current value held ≥ `MIN_STABLE` samples.
- `glitch` out 1: one-cycle pulse; change occurred while not settled.
- `hold_cnt` out `CNT_W`: consecutive samples of the current value, saturating.
- `glitch_cnt` out `CNT_W`: total glitches since reset, saturating.

## Operation
- Internal state machine: EMPTY (no sample yet), SETTLING, SETTLED; `prev` register holds the last sample.
- `rst`=1 at posedge:
  - state goes to EMPTY and `prev` to 0.
  - All outputs go to 0.
  - `rst` has priority over `en`.
- Sample (posedge, `en`=1, `rst`=0):
  - `prev` is loaded with `sig`.
  - EMPTY:
    - `hold_cnt`=1, `stable`=0, `change`=0, `glitch`=0.
    - Next state is SETTLED if `MIN_STABLE`=1, else SETTLING.
  - `sig`==`prev`:
    - `stable`=1, `change`=0, `glitch`=0.
    - `hold_cnt` increments, saturating at 2^`CNT_W`−1.
    - Enter SETTLED when the new `hold_cnt` ≥ `MIN_STABLE`.
  - `sig`!=`prev`:
    - `stable`=0, `change`=1, `hold_cnt`=1.
    - If the state was SETTLING: `glitch`=1 and `glitch_cnt` increments, saturating.
    - Next state is SETTLED if `MIN_STABLE`=1, else SETTLING.
- `settled` is 1 exactly in SETTLED.
- Non-sample edge (`en`=0):
  - `change`=0 and `glitch`=0.
  - All other state and outputs hold.
  - Bus activity while disabled is invisible; only the value at the next enabled sample is compared with `prev`.
- A change out of SETTLED is legal: `change` pulses and `glitch` stays 0.
- With `MIN_STABLE`=1, `glitch` never asserts.

## Timing
- All outputs are registered and update on the posedge that takes the sample, giving one cycle latency from `sig` to the outputs.
- `change` and `glitch` are high for exactly one cycle per event, including for back-to-back enabled changes.
- Reset takes effect at the first posedge with `rst`=1. Outputs read 0 in the following cycle.
- The first enabled edge after reset deassertion is the first sample.
- Reset during SETTLING or SETTLED discards history. No `glitch` is produced by reset.

## Configuration
- `STABLE_WINDOW_MONITOR_SVA_EN` defined: the block compiles embedded concurrent assertions, each gated off during `rst` and for any cycle whose preceding edge was not an enabled sample.
  - `stable` equals `$stable(sig)` sampled on enabled edges, checked via `prev`.
  - `glitch` implies `change`.
  - `glitch` never asserts with `MIN_STABLE`=1.
  - `hold_cnt` never decreases except to 1 on `change` or to 0 on reset.
  - Failures report `$error` with `$time`.
- Not defined: no assertion code; RTL behaviour is identical.

## Test plan
- Reset: `rst`=1 for 2 cycles with `sig`=0xFF, `en`=1 → all outputs 0 and `settled`=0 throughout.
- Settling (WIDTH=8, MIN_STABLE=3, CNT_W=4): `sig`=0x5A held for 5 samples → `hold_cnt` 1,2,3,4,5; `stable` 0,1,1,1,1; `settled` rises after the 3rd sample; `glitch`=0.
- Glitch: 0x11 for 2 samples, then 0x22 → `change`=1, `glitch`=1 for one cycle, `glitch_cnt`=1, `hold_cnt`=1; 0x22 held 3 samples, then 0x33 → `change`=1, `glitch`=0.
- Saturation: `sig` held 20 samples → `hold_cnt` stops at 15; 17 glitches (alternating 0x00/0x01 each sample) → `glitch_cnt` stops at 15.
- Enable gating: 2 samples of 0xA0, `en`=0 while `sig` toggles to 0x0B and back to 0xA0, `en`=1 → no `change`, `hold_cnt`=3.
- Reset mid-run: in SETTLING with `hold_cnt`=2, assert `rst` for 1 cycle while `sig` changes → outputs 0 and no `glitch`; next sample gives `hold_cnt`=1.
